mbist_response_analyzer: RTL and testbench

Downstream stage of the checkerboard MBIST address/data counter. Takes the counter's address, expected data, write-enable and terminal-count outputs, plus the SRAM read data. Delays the expected values to match SRAM read latency and compares them against the read data on every read cycle. Accumulates a saturating fail count, captures the first failure, and reports done/pass to the BIST controller.

---
 rtl/mbist_response_analyzer_if.sv | 40 ++++
 rtl/mbist_response_analyzer.sv | 218 +++++++++++++++++++++
 tb/tb_mbist_response_analyzer.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_response_analyzer_if.sv
// Bundle of signals between the MBIST counter/controller side and the
// response analyzer. The master modport is the counter + SRAM + BIST
// controller side; the slave modport is the analyzer itself.
interface mbist_response_analyzer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int FCNT_W = 8
);
  // controller / counter / SRAM to analyzer
  logic                     start;
  logic                     cen_in;
  logic                     we_in;
  logic [ADDR_W-1:0]        addr_in;
  logic [DATA_W-1:0]        exp_in;
  logic                     cout_in;
  logic [DATA_W-1:0]        sram_rdata;
  logic                     log_rd;
  // analyzer to controller
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [FCNT_W-1:0]        fail_cnt;
  logic [ADDR_W-1:0]        first_fail_addr;
  logic [DATA_W-1:0]        first_fail_syn;
  logic                     log_empty;
  logic [ADDR_W+DATA_W-1:0] log_data;
  logic                     log_ovf;

  modport master (
    output start, cen_in, we_in, addr_in, exp_in, cout_in, sram_rdata, log_rd,
    input  busy, done, pass, fail_cnt, first_fail_addr, first_fail_syn,
           log_empty, log_data, log_ovf
  );

  modport slave (
    input  start, cen_in, we_in, addr_in, exp_in, cout_in, sram_rdata, log_rd,
    output busy, done, pass, fail_cnt, first_fail_addr, first_fail_syn,
           log_empty, log_data, log_ovf
  );
endinterface

// File: rtl/mbist_response_analyzer.sv
// MBIST response analyzer: delays the counter's {addr, expected data} by the
// SRAM read latency, compares against SRAM read data on every read, keeps a
// saturating fail count plus the first failing address/syndrome, and reports
// busy/done/pass to the BIST controller.
// Optional mismatch log FIFO (4 entries) enabled by defining MBIST_FAIL_LOG_EN;
// without it the log ports are tied off (empty = 1, data = 0, ovf = 0).
// READ_LAT legal range is 1..4.
module mbist_response_analyzer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1,
  parameter int FCNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  mbist_response_analyzer_if.slave      bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              LOG_W      = ADDR_W + DATA_W;
  localparam logic [2:0]      DRAIN_INIT = 3'(READ_LAT - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = {FCNT_W{1'b1}};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [2:0]        r_drain_cnt;
  logic              r_pipe_v    [READ_LAT];
  logic [ADDR_W-1:0] r_pipe_addr [READ_LAT];
  logic [DATA_W-1:0] r_pipe_exp  [READ_LAT];
  logic [FCNT_W-1:0] r_fail_cnt;
  logic [ADDR_W-1:0] r_ff_addr;
  logic [DATA_W-1:0] r_ff_syn;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [1:0]        w_state_nxt;
  logic [2:0]        w_drain_nxt;
  logic [FCNT_W-1:0] w_fail_nxt;
  logic [ADDR_W-1:0] w_ff_addr_nxt;
  logic [DATA_W-1:0] w_ff_syn_nxt;
  logic              w_start_acc;
  logic              w_rd_issue;
  logic [DATA_W-1:0] w_syn;
  logic              w_mismatch;

  // start only counts when the analyzer is not already running a pass
  assign w_start_acc = bus.start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_rd_issue  = bus.cen_in & ~bus.we_in & (r_state == S_RUN);
  assign w_syn       = bus.sram_rdata ^ r_pipe_exp[READ_LAT-1];
  assign w_mismatch  = r_pipe_v[READ_LAT-1] & (w_syn != {DATA_W{1'b0}});

  // FSM next state and drain countdown
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
        else           w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (bus.cout_in) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = DRAIN_INIT;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == 3'd0) w_state_nxt = S_DONE;
        else                     w_drain_nxt = r_drain_cnt - 3'd1;
      end
      S_DONE: begin
        if (bus.start) w_state_nxt = S_RUN;
        else           w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_drain_nxt = 3'd0;
      end
    endcase
  end

  // fail counter and first-failure capture; a fresh run clears them
  always_comb begin
    w_fail_nxt    = r_fail_cnt;
    w_ff_addr_nxt = r_ff_addr;
    w_ff_syn_nxt  = r_ff_syn;
    if (w_start_acc) begin
      w_fail_nxt    = {FCNT_W{1'b0}};
      w_ff_addr_nxt = {ADDR_W{1'b0}};
      w_ff_syn_nxt  = {DATA_W{1'b0}};
    end else if (w_mismatch) begin
      if (r_fail_cnt != FCNT_MAX) w_fail_nxt = r_fail_cnt + FCNT_ONE;
      else                        w_fail_nxt = r_fail_cnt;
      if (r_fail_cnt == {FCNT_W{1'b0}}) begin
        w_ff_addr_nxt = r_pipe_addr[READ_LAT-1];
        w_ff_syn_nxt  = w_syn;
      end else begin
        w_ff_addr_nxt = r_ff_addr;
        w_ff_syn_nxt  = r_ff_syn;
      end
    end else begin
      w_fail_nxt = r_fail_cnt;
    end
  end

  // state, drain counter, result registers and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 3'd0;
      r_fail_cnt  <= {FCNT_W{1'b0}};
      r_ff_addr   <= {ADDR_W{1'b0}};
      r_ff_syn    <= {DATA_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_ff_addr   <= w_ff_addr_nxt;
      r_ff_syn    <= w_ff_syn_nxt;
      r_busy      <= (w_state_nxt == S_RUN) | (w_state_nxt == S_DRAIN);
      r_done      <= (w_state_nxt == S_DONE);
      r_pass      <= (w_state_nxt == S_DONE) & (w_fail_nxt == {FCNT_W{1'b0}});
    end
  end

  // alignment pipeline: stage 0 takes the issue, last stage meets sram_rdata
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      for (int k = 0; k < READ_LAT; k++) begin
        r_pipe_v[k]    <= 1'b0;
        r_pipe_addr[k] <= {ADDR_W{1'b0}};
        r_pipe_exp[k]  <= {DATA_W{1'b0}};
      end
    end else begin
      r_pipe_v[0]    <= w_rd_issue;
      r_pipe_addr[0] <= bus.addr_in;
      r_pipe_exp[0]  <= bus.exp_in;
      for (int k = 1; k < READ_LAT; k++) begin
        r_pipe_v[k]    <= r_pipe_v[k-1];
        r_pipe_addr[k] <= r_pipe_addr[k-1];
        r_pipe_exp[k]  <= r_pipe_exp[k-1];
      end
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.fail_cnt        = r_fail_cnt;
  assign bus.first_fail_addr = r_ff_addr;
  assign bus.first_fail_syn  = r_ff_syn;

`ifdef MBIST_FAIL_LOG_EN
  logic [LOG_W-1:0] r_log_mem [4];
  logic [1:0]       r_log_wp;
  logic [1:0]       r_log_rp;
  logic [2:0]       r_log_cnt;
  logic             r_log_ovf;
  logic             w_log_full;
  logic             w_log_empty;
  logic             w_log_pop;
  logic             w_log_push;
  logic             w_log_drop;

  assign w_log_full  = (r_log_cnt == 3'd4);
  assign w_log_empty = (r_log_cnt == 3'd0);
  assign w_log_pop   = bus.log_rd & ~w_log_empty;
  // a full FIFO still accepts a push when a pop frees a slot this cycle
  assign w_log_push  = w_mismatch & (~w_log_full | w_log_pop);
  assign w_log_drop  = w_mismatch & w_log_full & ~w_log_pop;

  // log pointers, occupancy and sticky overflow; a new run empties the log
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_log_wp  <= 2'd0;
      r_log_rp  <= 2'd0;
      r_log_cnt <= 3'd0;
      r_log_ovf <= 1'b0;
    end else begin
      if (w_log_push) r_log_wp <= r_log_wp + 2'd1;
      else            r_log_wp <= r_log_wp;
      if (w_log_pop)  r_log_rp <= r_log_rp + 2'd1;
      else            r_log_rp <= r_log_rp;
      case ({w_log_push, w_log_pop})
        2'b10:   r_log_cnt <= r_log_cnt + 3'd1;
        2'b01:   r_log_cnt <= r_log_cnt - 3'd1;
        default: r_log_cnt <= r_log_cnt;
      endcase
      if (w_log_drop) r_log_ovf <= 1'b1;
      else            r_log_ovf <= r_log_ovf;
    end
  end

  // log storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (w_log_push) r_log_mem[r_log_wp] <= {r_pipe_addr[READ_LAT-1], w_syn};
  end

  assign bus.log_empty = w_log_empty;
  assign bus.log_data  = r_log_mem[r_log_rp];
  assign bus.log_ovf   = r_log_ovf;
`else
  assign bus.log_empty = 1'b1;
  assign bus.log_data  = {LOG_W{1'b0}};
  assign bus.log_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_response_analyzer.sv
// Self-checking bench for mbist_response_analyzer. Drives checkerboard
// marches (256 writes then 256 reads), models the SRAM with injectable
// per-address XOR faults, and scoreboards the per-run result. Build with
// MBIST_FAIL_LOG_EN defined to exercise the mismatch log (READ_LAT = 3).
module tb_mbist_response_analyzer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int FCNT_W = 4;
`ifdef MBIST_FAIL_LOG_EN
  localparam int READ_LAT = 3;
`else
  localparam int READ_LAT = 1;
`endif

  typedef struct packed {
    logic [FCNT_W-1:0] fcnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] syn;
    logic              pass;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic [ADDR_W+DATA_W-1:0] log_q[$];

  logic [DATA_W-1:0] mem        [256];
  logic [DATA_W-1:0] fault_mask [256];
  logic [DATA_W-1:0] rd_pipe    [READ_LAT];

  always #5 clk = ~clk;

  mbist_response_analyzer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FCNT_W(FCNT_W)) bus ();

  mbist_response_analyzer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM model: writes store data, reads return stored data XOR fault mask
  // after READ_LAT cycles; non-read cycles return junk
  always @(posedge clk) begin
    if (bus.cen_in && bus.we_in) mem[bus.addr_in] <= bus.exp_in;
    if (bus.cen_in && !bus.we_in) rd_pipe[0] <= mem[bus.addr_in] ^ fault_mask[bus.addr_in];
    else                          rd_pipe[0] <= DATA_W'($urandom);
    for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.sram_rdata = rd_pipe[READ_LAT-1];

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[0] ? 4'b0101 : 4'b1010;
  endfunction

  task automatic drive_idle();
    bus.start   = 1'b0;
    bus.cen_in  = 1'b0;
    bus.we_in   = 1'b0;
    bus.addr_in = 8'h00;
    bus.exp_in  = 4'h0;
    bus.cout_in = 1'b0;
    bus.log_rd  = 1'b0;
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 256; a++) fault_mask[a] = 4'h0;
  endtask

  // full march; rst_at >= 0 asserts rst with that access and returns early,
  // mid_start >= 0 pulses start during that access (must be ignored)
  task automatic run_march(input int rst_at, input int mid_start);
    res_t r;
    int   nf;
    nf = 0;
    r  = '0;
    for (int a = 0; a < 256; a++) begin
      if (fault_mask[a] != 4'h0) begin
        if (nf == 0) begin
          r.addr = ADDR_W'(a);
          r.syn  = fault_mask[a];
        end
        nf++;
      end
    end
    r.fcnt = (nf > 15) ? 4'hF : FCNT_W'(nf);
    r.pass = (nf == 0);
    if (rst_at < 0) exp_q.push_back(r);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      bus.start   = (i == mid_start);
      bus.cen_in  = 1'b1;
      bus.we_in   = (i < 256);
      bus.addr_in = ADDR_W'(i);
      bus.exp_in  = pat(ADDR_W'(i));
      bus.cout_in = (i == 511);
      if (i == rst_at) begin
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  // waits for done, pops the expected result and compares
  task automatic wait_done(input string tag);
    res_t e;
    int   n;
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%0b after %0d cycles, required 1", tag, bus.done, n);
    end
    checks++;
    if (n != READ_LAT + 1) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles, required %0d", tag, n, READ_LAT + 1);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got 0 entries, required 1", tag);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.fail_cnt !== e.fcnt) begin
      errors++;
      $display("FAIL %s fail_cnt: got %0h, required %0h", tag, bus.fail_cnt, e.fcnt);
    end
    checks++;
    if (bus.first_fail_addr !== e.addr) begin
      errors++;
      $display("FAIL %s first_fail_addr: got %0h, required %0h", tag, bus.first_fail_addr, e.addr);
    end
    checks++;
    if (bus.first_fail_syn !== e.syn) begin
      errors++;
      $display("FAIL %s first_fail_syn: got %0b, required %0b", tag, bus.first_fail_syn, e.syn);
    end
    checks++;
    if (bus.pass !== e.pass || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pass_busy: got pass=%0b busy=%0b, required pass=%0b busy=0",
               tag, bus.pass, bus.busy, e.pass);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000 || bus.fail_cnt !== 4'h0 ||
        bus.first_fail_addr !== 8'h00 || bus.first_fail_syn !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b pass=%0b fcnt=%0h ffa=%0h ffs=%0h, required all 0",
               bus.busy, bus.done, bus.pass, bus.fail_cnt, bus.first_fail_addr, bus.first_fail_syn);
    end
    checks++;
    if (bus.log_empty !== 1'b1 || bus.log_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_log: got empty=%0b ovf=%0b, required empty=1 ovf=0", bus.log_empty, bus.log_ovf);
    end
  endtask

  task automatic test_clean();
    clear_faults();
    run_march(-1, -1);
    wait_done("clean");
  endtask

  // junk reads and cout toggles in DONE must not disturb the held result
  task automatic test_done_hold();
    logic [FCNT_W-1:0] f;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] s;
    logic              p;
    f = 4'h1; a = 8'h3C; s = 4'b0100; p = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cen_in  = 1'b1;
      bus.we_in   = 1'b0;
      bus.addr_in = ADDR_W'($urandom);
      bus.exp_in  = DATA_W'($urandom);
      bus.cout_in = 1'($urandom);
      @(negedge clk);
    end
    drive_idle();
    checks++;
    if (bus.done !== 1'b1 || bus.fail_cnt !== f || bus.first_fail_addr !== a ||
        bus.first_fail_syn !== s || bus.pass !== p) begin
      errors++;
      $display("FAIL done_hold: got done=%0b fcnt=%0h ffa=%0h ffs=%0b pass=%0b, required 1 %0h %0h %0b %0b",
               bus.done, bus.fail_cnt, bus.first_fail_addr, bus.first_fail_syn, bus.pass, f, a, s, p);
    end
  endtask

  task automatic test_single_fault();
    clear_faults();
    fault_mask[8'h3C] = 4'b0100;   // reads back 1110 where 1010 is expected
    run_march(-1, -1);
    wait_done("single_fault");
  endtask

  task automatic test_multi_fault();
    clear_faults();
    fault_mask[8'h05] = 4'b0001;
    fault_mask[8'h80] = 4'b1000;
    run_march(-1, 300);            // start mid-run is ignored
    wait_done("multi_fault");
  endtask

  task automatic test_saturation();
    for (int a = 0; a < 256; a++) fault_mask[a] = DATA_W'($urandom_range(1, 15));
    run_march(-1, -1);
    wait_done("saturation");
  endtask

  task automatic test_reset_mid_run();
    clear_faults();
    fault_mask[8'h05] = 4'b0010;
    run_march(256 + 8'h40, -1);
    checks++;
    if (bus.fail_cnt !== 4'h1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got fcnt=%0h busy=%0b, required fcnt=1 busy=1", bus.fail_cnt, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.fail_cnt !== 4'h0 || bus.first_fail_addr !== 8'h00 ||
        bus.first_fail_syn !== 4'h0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%0b fcnt=%0h ffa=%0h ffs=%0b done=%0b pass=%0b, required all 0",
               bus.busy, bus.fail_cnt, bus.first_fail_addr, bus.first_fail_syn, bus.done, bus.pass);
    end
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    clear_faults();
    run_march(-1, -1);
    wait_done("after_reset");
  endtask

  task automatic test_start_with_rst();
    bus.start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst: got busy=%0b done=%0b, required busy=0 done=0", bus.busy, bus.done);
    end
  endtask

  task automatic test_log();
`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_W+DATA_W-1:0] e;
    logic [ADDR_W-1:0] fa [6];
    logic [DATA_W-1:0] fs [6];
    fa[0] = 8'h10; fa[1] = 8'h20; fa[2] = 8'h30; fa[3] = 8'h40; fa[4] = 8'h50; fa[5] = 8'h60;
    fs[0] = 4'h1;  fs[1] = 4'h2;  fs[2] = 4'h4;  fs[3] = 4'h8;  fs[4] = 4'h3;  fs[5] = 4'h6;
    clear_faults();
    for (int k = 0; k < 6; k++) begin
      fault_mask[fa[k]] = fs[k];
      if (k < 4) log_q.push_back({fa[k], fs[k]});
    end
    run_march(-1, -1);
    wait_done("log_run");
    for (int k = 0; k < 4; k++) begin
      e = log_q.pop_front();
      checks++;
      if (bus.log_empty !== 1'b0 || bus.log_data !== e) begin
        errors++;
        $display("FAIL log_pop%0d: got empty=%0b data=%0h, required empty=0 data=%0h",
                 k, bus.log_empty, bus.log_data, e);
      end
      bus.log_rd = 1'b1;
      @(negedge clk);
      bus.log_rd = 1'b0;
    end
    checks++;
    if (bus.log_empty !== 1'b1 || bus.log_ovf !== 1'b1) begin
      errors++;
      $display("FAIL log_after_pops: got empty=%0b ovf=%0b, required empty=1 ovf=1", bus.log_empty, bus.log_ovf);
    end
    bus.log_rd = 1'b1;             // pop on empty is ignored
    @(negedge clk);
    bus.log_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.log_empty !== 1'b1 || bus.log_ovf !== 1'b1) begin
      errors++;
      $display("FAIL log_empty_pop: got empty=%0b ovf=%0b, required empty=1 ovf=1", bus.log_empty, bus.log_ovf);
    end
`else
    clear_faults();
    fault_mask[8'h21] = 4'b0011;
    run_march(-1, -1);
    wait_done("log_off_run");
    bus.log_rd = 1'b1;
    @(negedge clk);
    bus.log_rd = 1'b0;
    checks++;
    if (bus.log_empty !== 1'b1 || bus.log_data !== 12'h000 || bus.log_ovf !== 1'b0) begin
      errors++;
      $display("FAIL log_tied_off: got empty=%0b data=%0h ovf=%0b, required 1 0 0",
               bus.log_empty, bus.log_data, bus.log_ovf);
    end
`endif
  endtask

  // cout already high at start: RUN, DRAIN, DONE with no reads, pass = 1
  task automatic test_empty_run();
    res_t r;
    r = '0;
    r.pass = 1'b1;
    exp_q.push_back(r);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cout_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.log_ovf !== 1'b0 || bus.log_empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_run_start: got busy=%0b done=%0b ovf=%0b empty=%0b, required 1 0 0 1",
               bus.busy, bus.done, bus.log_ovf, bus.log_empty);
    end
    @(negedge clk);
    drive_idle();
    wait_done("empty_run");
  endtask

  initial begin
    clear_faults();
    for (int k = 0; k < READ_LAT; k++) rd_pipe[k] = 4'h0;
    test_reset();
    test_clean();
    test_single_fault();
    test_done_hold();
    test_multi_fault();
    test_saturation();
    test_reset_mid_run();
    test_start_with_rst();
    test_log();
    test_empty_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
